// File: rtl/manch_pkg.sv
// Shared definitions for the Manchester link.
//   manch_state_e    : receiver tracking state (StHunt, StTrack).
//   manch_fullbaud() : clock cycles per line bit, CLK_FREQ / BAUDRATE.
//   manch_q()        : quarter-bit, shortest legal interval to a boundary edge.
//   manch_long_min() : shortest accepted mid-bit to mid-bit interval (3/4 bit).
//   manch_long_max() : longest accepted mid-bit to mid-bit interval (5/4 bit).
// All helpers use integer division so the encoder and decoder agree exactly.
package manch_pkg;

    typedef enum logic {
        StHunt  = 1'b0,
        StTrack = 1'b1
    } manch_state_e;

    function automatic int unsigned manch_fullbaud(input int unsigned clk_freq,
                                                   input int unsigned baudrate);
        return clk_freq / baudrate;
    endfunction

    function automatic int unsigned manch_q(input int unsigned fullbaud);
        return fullbaud / 4;
    endfunction

    function automatic int unsigned manch_long_min(input int unsigned fullbaud);
        return (fullbaud * 3) / 4;
    endfunction

    function automatic int unsigned manch_long_max(input int unsigned fullbaud);
        return (fullbaud * 5) / 4;
    endfunction

endpackage

// File: rtl/manch_rx_sync.sv
// Receive front end for the Manchester decoder.
// Brings the asynchronous line into the clk domain through two flops, optionally
// cleans it with a 3-sample majority filter, and flags level changes.
// Build option: define MANCH_GLITCH_FILTER_EN to insert the majority filter
// (suppresses single-cycle glitches, adds 2 cycles of latency).
// Ports:
//   clk      : clock, all logic on posedge
//   rst_n    : asynchronous active-low reset, all flops clear to 0
//   rx_i     : raw asynchronous line
//   level_o  : cleaned, synchronised line level
//   edge_o   : high for one cycle when level_o differs from its previous value
module manch_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic level_o,
    output logic edge_o
);

    logic sync1_q, sync2_q;
    logic prev_q;
    logic level_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef MANCH_GLITCH_FILTER_EN
    logic hist1_q, hist2_q;
    logic filt_d, filt_q;

    // Two of the last three synchronised samples must agree before the level moves.
    always_comb begin
        filt_d = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            filt_q  <= filt_d;
        end
    end

    assign level_w = filt_q;
`else
    assign level_w = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_w;
        end
    end

    assign level_o = level_w;
    assign edge_o  = level_w ^ prev_q;

endmodule

// File: rtl/manch_decoder.sv
// Manchester receiver (bit 1 = low-then-high, bit 0 = high-then-low).
// Measures the interval between line edges, locks onto mid-bit transitions and
// emits one recovered bit per mid-bit edge. Boundary edges between equal bits are
// tolerated once per bit; any other timing is a coding violation that drops lock.
// Build option: MANCH_GLITCH_FILTER_EN (see manch_rx_sync) adds a majority filter.
// Ports:
//   clk      : clock, all logic on posedge
//   rst_n    : asynchronous active-low reset
//   rx_manch : asynchronous Manchester line
//   rx_data  : last recovered bit, held until the next one
//   rx_valid : one-cycle pulse per recovered bit
//   locked   : high while tracking mid-bit transitions
//   code_err : one-cycle pulse on a coding violation
module manch_decoder
    import manch_pkg::*;
#(
    parameter int unsigned BAUDRATE = 115200,
    parameter int unsigned CLK_FREQ = 18_750_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_manch,
    output logic rx_data,
    output logic rx_valid,
    output logic locked,
    output logic code_err
);

    localparam int unsigned FullBaud = manch_fullbaud(CLK_FREQ, BAUDRATE);
    localparam int unsigned QCycles  = manch_q(FullBaud);
    localparam int unsigned LongMin  = manch_long_min(FullBaud);
    localparam int unsigned LongMax  = manch_long_max(FullBaud);
    localparam int unsigned CntW     = $clog2(LongMax + 2);

    localparam logic [CntW-1:0] CntQ       = CntW'(QCycles);
    localparam logic [CntW-1:0] CntLongMin = CntW'(LongMin);
    localparam logic [CntW-1:0] CntLongMax = CntW'(LongMax);
    localparam logic [CntW-1:0] CntSat     = CntW'(LongMax + 1);

    logic level_w, edge_w;

    manch_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_i    (rx_manch),
        .level_o (level_w),
        .edge_o  (edge_w)
    );

    manch_state_e    state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            bnd_d, bnd_q;     // boundary edge already seen in this bit
    logic            data_d, data_q;
    logic            valid_d, valid_q;
    logic            err_d, err_q;
    logic            in_win;
    logic            mid, viol;

    assign in_win = (cnt_q >= CntLongMin) && (cnt_q <= CntLongMax);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bnd_d   = bnd_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        mid     = 1'b0;
        viol    = 1'b0;

        if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntW'(1);
        end

        case (state_q)
            StHunt: begin
                // Any edge restarts the measurement; only a full-period gap locks.
                if (edge_w) begin
                    cnt_d = '0;
                    mid   = in_win;
                end
            end
            StTrack: begin
                // Saturation wins over a coincident edge: the bit is already overdue.
                if (cnt_q == CntSat) begin
                    viol = 1'b1;
                end else if (edge_w) begin
                    if (cnt_q < CntQ) begin
                        viol = 1'b1;
                    end else if (cnt_q < CntLongMin) begin
                        if (bnd_q) begin
                            viol = 1'b1;
                        end else begin
                            bnd_d = 1'b1;
                        end
                    end else begin
                        mid = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase

        if (mid) begin
            state_d = StTrack;
            cnt_d   = '0;
            bnd_d   = 1'b0;
            data_d  = level_w;
            valid_d = 1'b1;
        end

        if (viol) begin
            state_d = StHunt;
            cnt_d   = '0;
            bnd_d   = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHunt;
            cnt_q   <= '0;
            bnd_q   <= 1'b0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bnd_q   <= bnd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign locked   = (state_q == StTrack);
    assign code_err = err_q;

endmodule

// File: tb/tb_manch_decoder.sv
// Self-checking bench for manch_decoder.
// Stimulus is built as a list of line segments (level, duration). When each
// segment is driven, an event-level model classifies the line edge by the gap
// since the last reference point and queues the expected rx_valid / code_err
// events with their cycle. A separate monitor pops and compares on every output.
module tb_manch_decoder;

    localparam int unsigned BaudRate = 115200;
    localparam int unsigned ClkFreq  = 18_750_000;
    localparam int FullBaud = ClkFreq / BaudRate;
    localparam int QCyc     = FullBaud / 4;
    localparam int LongMin  = (FullBaud * 3) / 4;
    localparam int LongMax  = (FullBaud * 5) / 4;
`ifdef MANCH_GLITCH_FILTER_EN
    localparam int Lat  = 5;
    localparam bit Filt = 1'b1;
`else
    localparam int Lat  = 3;
    localparam bit Filt = 1'b0;
`endif

    logic clk, rst_n, rx_manch;
    logic rx_data, rx_valid, locked, code_err;

    manch_decoder #(
        .BAUDRATE (BaudRate),
        .CLK_FREQ (ClkFreq)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_manch (rx_manch),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .locked   (locked),
        .code_err (code_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        int t;
        bit err;
        bit data;
    } ev_t;

    ev_t exp_q[$];

    bit m_track = 1'b0;
    bit m_bnd   = 1'b0;
    bit m_data  = 1'b0;
    int m_ref   = -1000;  // cycle of last counter clear
    int m_to    = -1;     // cycle of last timeout

    task automatic push_ev(input int t, input bit err, input bit data);
        ev_t e;
        e.t    = t;
        e.err  = err;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Timeout: locked and no mid-bit edge for LongMax+2 cycles after the last clear.
    task automatic model_advance(input int limit);
        int t_to;
        t_to = m_ref + LongMax + 2;
        if (m_track && t_to <= limit) begin
            push_ev(t_to, 1'b1, m_data);
            m_track = 1'b0;
            m_bnd   = 1'b0;
            m_ref   = t_to;
            m_to    = t_to;
        end
    endtask

    // d is the cycle on which the decoder decides about this line edge.
    task automatic model_edge(input int d, input bit lvl);
        int c;
        model_advance(d);
        if (m_to == d) return;
        c = d - m_ref - 1;
        if (c > LongMax + 1) c = LongMax + 1;
        m_ref = d;
        if (!m_track) begin
            if (c >= LongMin && c <= LongMax) begin
                m_track = 1'b1;
                m_bnd   = 1'b0;
                m_data  = lvl;
                push_ev(d, 1'b0, lvl);
            end
        end else if (c < QCyc || (c < LongMin && m_bnd)) begin
            m_track = 1'b0;
            m_bnd   = 1'b0;
            push_ev(d, 1'b1, m_data);
        end else if (c < LongMin) begin
            m_bnd = 1'b1;
            m_ref = d - c - 1;  // boundary edge leaves the measurement running
        end else begin
            m_bnd  = 1'b0;
            m_data = lvl;
            push_ev(d, 1'b0, lvl);
        end
    endtask

    // ------------------------------------------------------------ stimulus
    bit seg_lvl[$];
    int seg_dur[$];
    bit seg_gl[$];
    bit line_lvl = 1'b0;

    task automatic add_half(input bit lvl, input int dur);
        int n;
        n = seg_lvl.size();
        if (n > 0 && seg_lvl[n-1] == lvl && !seg_gl[n-1]) begin
            seg_dur[n-1] = seg_dur[n-1] + dur;
        end else begin
            seg_lvl.push_back(lvl);
            seg_dur.push_back(dur);
            seg_gl.push_back(1'b0);
        end
    endtask

    task automatic add_bit(input bit b, input int period);
        add_half(!b, period / 2);
        add_half(b, period - period / 2);
    endtask

    task automatic add_idle(input int dur);
        int n;
        n = seg_lvl.size();
        add_half((n > 0) ? seg_lvl[n-1] : line_lvl, dur);
    endtask

    task automatic add_glitch(input bit lvl);
        seg_lvl.push_back(lvl);
        seg_dur.push_back(1);
        seg_gl.push_back(1'b1);
    endtask

    // Called at a negedge; returns at the negedge after the last segment.
    task automatic play();
        bit prev_gl;
        prev_gl = 1'b0;
        while (seg_lvl.size() > 0) begin
            bit lvl;
            int dur;
            bit gl;
            int d;
            lvl = seg_lvl.pop_front();
            dur = seg_dur.pop_front();
            gl  = seg_gl.pop_front();
            d   = cyc + Lat;
            if (lvl != line_lvl) begin
                rx_manch = lvl;
                line_lvl = lvl;
                if (!(Filt && (gl || prev_gl))) model_edge(d, lvl);
            end
            model_advance(d + dur - 1);
            prev_gl = gl;
            repeat (dur) @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------- monitor
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_event: got none, expected err=%0d at cycle %0d (now %0d)",
                         exp_q[0].err, exp_q[0].t, cyc);
                void'(exp_q.pop_front());
            end
            if (rx_valid || code_err) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: got valid=%0d err=%0d, expected none (cycle %0d)",
                             rx_valid, code_err, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_time", cyc, e.t);
                    check("event_kind", {rx_valid, code_err}, e.err ? 2 'b01 : 2'b10);
                    check("rx_data", rx_data, e.data);
                    check("locked", locked, e.err ? 0 : 1);
                end
            end
        end
    end

    // ---------------------------------------------------------------- main
    initial begin
        int p;
        rst_n    = 1'b1;
        rx_manch = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_locked", locked, 0);
        check("reset_code_err", code_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_ref = cyc;

        // Preamble 0,1,0,1 then 1,1,0,1,0.
        add_idle(300);
        add_bit(0, FullBaud); add_bit(1, FullBaud); add_bit(0, FullBaud); add_bit(1, FullBaud);
        add_bit(1, FullBaud); add_bit(1, FullBaud); add_bit(0, FullBaud); add_bit(1, FullBaud);
        add_bit(0, FullBaud);
        play();

        // Hold constant while locked: timeout.
        add_idle(250);
        play();

        // All ones never lock; a single 0 then does.
        for (int i = 0; i < 50; i++) add_bit(1, FullBaud);
        add_bit(0, FullBaud);
        for (int i = 0; i < 6; i++) add_bit(1'($urandom), FullBaud);
        add_bit(1, FullBaud);
        play();

        // Two edges 20 cycles apart after a mid-bit edge.
        add_half(1'b0, FullBaud / 2);
        add_half(1'b1, 50);
        add_half(1'b0, 20);
        add_half(1'b1, FullBaud - FullBaud / 2 - 70);
        for (int i = 0; i < 8; i++) add_bit(i[0], FullBaud);
        play();

        // Short and long bit periods, then random data at a random period.
        for (int i = 0; i < 10; i++) add_bit(i[0], 125);
        for (int i = 0; i < 10; i++) add_bit(i[0], 200);
        p = $urandom_range(200, 125);
        for (int i = 0; i < 4; i++) add_bit(i[0], p);
        for (int i = 0; i < 12; i++) add_bit(1'($urandom), p);
        add_bit(1, p);
        play();

        // Asynchronous reset mid-bit while locked.
        add_bit(0, FullBaud); add_bit(1, FullBaud);
        play();
        repeat (40) @(negedge clk);
        check("pre_reset_locked", locked, m_track);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_rx_data", rx_data, 0);
        check("async_rst_rx_valid", rx_valid, 0);
        check("async_rst_locked", locked, 0);
        check("async_rst_code_err", code_err, 0);
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].t > cyc) void'(exp_q.pop_back());
        rx_manch = 1'b0;
        line_lvl = 1'b0;
        repeat (4) @(negedge clk);
        rst_n   = 1'b1;
        m_track = 1'b0;
        m_bnd   = 1'b0;
        m_data  = 1'b0;
        m_ref   = cyc;
        m_to    = -1;
        add_idle(300);
        for (int i = 0; i < 4; i++) add_bit(i[0], FullBaud);
        for (int i = 0; i < 8; i++) add_bit(1'($urandom), FullBaud);
        play();

        // One-cycle glitch mid-half while locked.
        add_bit(1, FullBaud);
        add_half(1'b0, FullBaud / 2);
        add_half(1'b1, 30);
        add_glitch(1'b0);
        add_half(1'b1, FullBaud - FullBaud / 2 - 31);
        for (int i = 0; i < 8; i++) add_bit(i[0], FullBaud);
        add_idle(300);
        play();

        repeat (Lat + 3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/manch_decoder.md
# manch_decoder

Manchester receiver that recovers the bit stream produced by the team's Manchester encoder (bit 1 = low-then-high, bit 0 = high-then-low, continuous with no idle gaps).

- Synchronises the serial line and locks onto mid-bit transitions using edge-interval measurement.
- Emits one `rx_data`/`rx_valid` pair per recovered bit.
- Flags coding violations and drops lock on them.
- Sits on the receive side of the link, feeding framing/deserialisation logic.

## Interface
- `BAUDRATE`, 115200, line bit rate (bits/s).
- `CLK_FREQ`, 18_750_000, `clk` frequency (Hz); `FULLBAUD = CLK_FREQ/BAUDRATE` (162 at defaults).
- `clk` input 1: single clock, all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_manch` input 1: asynchronous Manchester line.
- `rx_data` output 1: last recovered bit; held until the next bit.
- `rx_valid` output 1: one-cycle pulse per recovered bit.
- `locked` output 1: high while tracking mid-bit transitions.
- `code_err` output 1: one-cycle pulse on a coding violation.

## Operation
- Front end:
  - 2-FF synchroniser on `rx_manch`; synchroniser flops reset to 0.
  - Edge detect compares the synchronised sample with the previous sample.
- Interval counter `cnt`:
  - Width `$clog2(LONG_MAX+2)`.
  - Cleared to 0 on each accepted mid-bit edge (TRACK) or on any edge (HUNT).
  - Otherwise increments, saturating at `LONG_MAX+1`.
- Window constants (integer division):
  - `Q = FULLBAUD/4` (40)
  - `LONG_MIN = FULLBAUD*3/4` (121)
  - `LONG_MAX = FULLBAUD*5/4` (202)
- States:
  - HUNT (reset state), `locked=0`:
    - Any edge: if `LONG_MIN <= cnt <= LONG_MAX`, the edge is a mid-bit edge → go to TRACK, `cnt<=0`, and emit the bit (`rx_data` = new line level, `rx_valid` pulse).
    - Otherwise stay in HUNT with `cnt<=0`.
    - No `code_err` is raised in HUNT.
  - TRACK, `locked=1`:
    - Edge with `cnt < Q`: violation.
    - Edge with `Q <= cnt < LONG_MIN`: boundary edge; allowed once per bit, and a second one is a violation. It does not clear `cnt`.
    - Edge with `LONG_MIN <= cnt <= LONG_MAX`: mid-bit edge → `rx_data` = new level (rising edge = 1, falling edge = 0), `rx_valid` pulse, `cnt<=0`, boundary flag cleared.
    - `cnt` reaching `LONG_MAX+1` with no edge: violation.
  - On violation: `code_err` pulses for 1 cycle, state returns to HUNT, `cnt<=0`, no `rx_valid`, and `rx_data` keeps its last value.
- Alternating-bit traffic (full-period pulses) is required to acquire lock. A constant all-1 or all-0 stream never locks, which is correct behaviour.

## Timing
- Reset values: `rx_data=0`, `rx_valid=0`, `locked=0`, `code_err=0`, state HUNT, `cnt=0`. Outputs clear immediately on `rst_n` low and work resumes on the first posedge after release.
- Latency:
  - `rx_valid` is asserted 3 posedges after the first posedge that samples the new `rx_manch` level: 2 synchroniser stages plus 1 registered decision.
  - `rx_valid`, `rx_data` and `locked` change on the same edge.
- `code_err` timing: asserted on the same relative edge as `rx_valid` would be, or on the edge where `cnt` hits `LONG_MAX+1`.
- Tolerated bit period: `LONG_MIN..LONG_MAX` cycles between consecutive mid-bit edges (about ±25%).
- Simultaneous events: an edge on the cycle `cnt` saturates counts as timeout. Reset dominates everything.

## Configuration
- `MANCH_GLITCH_FILTER_EN` defined:
  - A 3-sample majority filter sits after the synchroniser.
  - Single-cycle glitches are suppressed.
  - Latency grows by 2 cycles, to 5 posedges.
- Undefined: no filter, 3-posedge latency; a 1-cycle glitch produces edges (normally a violation).

## Structure
- Package `manch_pkg`:
  - State encoding (HUNT, TRACK).
  - Function `manch_fullbaud(CLK_FREQ, BAUDRATE)`.
  - Window constant helpers (`Q`, `LONG_MIN`, `LONG_MAX`), shared with the encoder.
- Sub-module `manch_rx_sync`: synchroniser, optional glitch filter, edge/level outputs.
- Top level: counter, FSM and output registers.

## Test plan
- Encoder-driven stream at defaults: preamble 0,1,0,1 then 1,1,0,1,0 → lock on the first full-period pulse; subsequent bits decoded in order, `rx_valid` every 162 ±1 cycles.
- All-ones stream for 50 bits → `locked` stays 0, no `rx_valid`, no `code_err`. Then one 0 bit → lock within 2 bits.
- While locked, hold the line constant for 250 cycles → `code_err` pulse when `cnt` reaches 203, `locked=0`, no `rx_valid`.
- While locked, inject two edges 20 cycles apart after a mid-bit edge → `code_err` on the second edge, return to HUNT.
- Bit period 125, then 200 cycles with alternating data → all bits decoded, no `code_err`.
- Assert `rst_n` mid-bit while locked → all outputs 0 asynchronously, relock after release. With `MANCH_GLITCH_FILTER_EN`, a 1-cycle glitch mid-bit is ignored, with no `code_err`.
